systolic_sequencer: RTL
=======================

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter OUT_LAT, default 2: cycles from a value on sys_data_in_11 to its column-1 result on sys_data_out_21.
REQ-002 SHALL have ports: clk in 1, single clock; rst in 1, reset (asynchronous, active-high).
REQ-003 SHALL have ports: start in 1, job request; n_rows in 8, rows in the job; busy out 1; done out 1.
REQ-004 SHALL have ports: w_11, w_12, w_21, w_22 in 16 each, Q8.8 weight matrix, sampled when start is accepted.
REQ-005 SHALL have ports: in_valid in 1; in_ready out 1; in_x1, in_x2 in 16 each, one input row.
REQ-006 SHALL have ports: sys_accept_w_1, sys_accept_w_2, sys_switch_in out 1 each; sys_weight_in_11, sys_weight_in_12 out 16 each; sys_data_in_11, sys_data_in_21 out 16 each.
REQ-007 SHALL have ports: sys_data_out_21, sys_data_out_22 in 16 each, array results.
REQ-008 SHALL have ports: res_valid out 1; res_y1, res_y2 out 16 each, one deskewed result row.

Function
REQ-009 SHALL use FSM states IDLE, LOAD0, LOAD1, LOAD2, STREAM, DRAIN.
REQ-010 In IDLE, start=1 with n_rows!=0 SHALL latch the weights and n_rows, then go to LOAD0; start with n_rows=0, or start in any other state, SHALL be ignored.
REQ-011 LOAD0 SHALL drive sys_weight_in_11=w_21 and sys_accept_w_1=1.
REQ-012 LOAD1 SHALL drive sys_weight_in_11=w_11, sys_accept_w_1=1, sys_weight_in_12=w_22 and sys_accept_w_2=1.
REQ-013 LOAD2 SHALL drive sys_accept_w_1=0, sys_weight_in_12=w_12, sys_accept_w_2=1 and sys_switch_in=1 for exactly one cycle.
REQ-014 Outside LOAD0-LOAD2, all accept/switch outputs SHALL be 0 and the weight outputs SHALL be 0.
REQ-015 in_ready SHALL be 1 in LOAD1, LOAD2 and STREAM while rows_left>0, and 0 otherwise.
REQ-016 A row transfers when in_valid & in_ready; each transfer SHALL decrement rows_left.
REQ-017 sys_data_in_11 SHALL be registered: it carries in_x1 in the cycle after the transfer, and 0 in any cycle without a transfer (bubble).
REQ-018 sys_data_in_21 SHALL carry the same row's in_x2 one cycle later than its in_x1 (skew register); bubbles propagate as 0.
REQ-019 The first row, if transferred in LOAD1, SHALL appear on sys_data_in_11 in the same cycle as sys_switch_in=1.
REQ-020 LOAD2 SHALL always go to STREAM; STREAM SHALL go to DRAIN on the edge where rows_left reaches 0.
REQ-021 SHALL keep a valid-tag shift register marking which sys_data_in_11 cycles carried real rows.
REQ-022 SHALL capture sys_data_out_21 at tag age OUT_LAT, then register it together with sys_data_out_22 at age OUT_LAT+1.
REQ-023 res_valid, res_y1 and res_y2 SHALL therefore be asserted exactly OUT_LAT+2 cycles after the row was on sys_data_in_11, one pulse per row, in input order.
REQ-024 Result pulses SHALL be gapped exactly as the input rows were.
REQ-025 The result interface has no backpressure.
REQ-026 DRAIN SHALL feed zeros and remain until the tag pipe is empty and the last res_valid has issued.
REQ-027 DRAIN SHALL then pulse done=1 for one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Data SHALL pass through unmodified (Q8.8, 16 bits); the block performs no arithmetic on data.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, clear rows_left, the skew register and the tag pipe, and drive every output to 0.
REQ-031 rst asserted mid-job SHALL discard the job with no done and no further res_valid.
REQ-032 After rst deasserts, the block SHALL accept a new start.

Verification
REQ-033 Basic job: n_rows=3, weights w_11=0x004C, w_12=0x0017, w_21=0xFF6C, w_22=0x006C, rows (2,2),(1,1),(1,0), in_valid held 1 -> accept/switch pattern exactly as REQ-011..013; sys_data_in_11 sequence 0x0200,0x0100,0x0100; sys_data_in_21 the same row sequence delayed 1 cycle; 3 res_valid pulses; done 1 cycle after the last.
REQ-034 Bubble: in_valid low for 2 cycles between rows 1 and 2 -> zeros on the data lanes during the gap; res_valid pulses separated by the same gap.
REQ-035 Latency: with a scoreboard model of the array -> each res_valid occurs exactly OUT_LAT+2 cycles after its row on sys_data_in_11, with res_y1/res_y2 matching the model.
REQ-036 Ignored start: start during STREAM, and start with n_rows=0 in IDLE -> no state change, no extra load sequence.
REQ-037 Reset mid-STREAM: rst pulsed after row 1 -> all outputs 0 the same cycle, no done; a new job then completes normally.
REQ-038 Single row: n_rows=1, in_valid first high in STREAM -> switch has no data alongside it; exactly one result; done asserted.

Source files
------------

// File: rtl/systolic_sequencer.sv
// Load sequencer and deskew front/back end for a 2x2 weight-stationary systolic array.
// It loads the Q8.8 weights, streams skewed input rows, then realigns and emits the result rows.
module systolic_sequencer #(
    parameter int OUT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  n_rows,
    output logic        busy,
    output logic        done,
    input  logic [15:0] w_11,
    input  logic [15:0] w_12,
    input  logic [15:0] w_21,
    input  logic [15:0] w_22,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x1,
    input  logic [15:0] in_x2,
    output logic        sys_accept_w_1,
    output logic        sys_accept_w_2,
    output logic        sys_switch_in,
    output logic [15:0] sys_weight_in_11,
    output logic [15:0] sys_weight_in_12,
    output logic [15:0] sys_data_in_11,
    output logic [15:0] sys_data_in_21,
    input  logic [15:0] sys_data_out_21,
    input  logic [15:0] sys_data_out_22,
    output logic        res_valid,
    output logic [15:0] res_y1,
    output logic [15:0] res_y2
);

    localparam int TAG_W = OUT_LAT + 2;

    typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, STREAM, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       rows_left_q, rows_left_d;
    logic [15:0]      w11_q, w11_d, w12_q, w12_d, w21_q, w21_d, w22_q, w22_d;
    logic [15:0]      data11_q, data11_d;
    logic [15:0]      x2_skew_q, x2_skew_d;
    logic [15:0]      data21_q, data21_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      y1_cap_q, y1_cap_d;
    logic             res_valid_q, res_valid_d;
    logic [15:0]      res_y1_q, res_y1_d;
    logic [15:0]      res_y2_q, res_y2_d;
    logic             xfer;

    // NOTE: every output of this block gets a default before the case, so no path leaves a latch behind.
    always_comb begin
        state_d          = state_q;
        rows_left_d      = rows_left_q;
        w11_d            = w11_q;
        w12_d            = w12_q;
        w21_d            = w21_q;
        w22_d            = w22_q;
        sys_accept_w_1   = 1'b0;
        sys_accept_w_2   = 1'b0;
        sys_switch_in    = 1'b0;
        sys_weight_in_11 = 16'd0;
        sys_weight_in_12 = 16'd0;
        done             = 1'b0;
        busy             = (state_q != IDLE);
        in_ready         = ((state_q == LOAD1) || (state_q == LOAD2) || (state_q == STREAM))
                           && (rows_left_q != 8'd0);
        xfer             = in_valid && in_ready;

        if (xfer) begin
            rows_left_d = rows_left_q - 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (start && (n_rows != 8'd0)) begin
                    w11_d       = w_11;
                    w12_d       = w_12;
                    w21_d       = w_21;
                    w22_d       = w_22;
                    rows_left_d = n_rows;
                    state_d     = LOAD0;
                end
            end
            LOAD0: begin
                sys_weight_in_11 = w21_q;
                sys_accept_w_1   = 1'b1;
                state_d          = LOAD1;
            end
            LOAD1: begin
                sys_weight_in_11 = w11_q;
                sys_accept_w_1   = 1'b1;
                sys_weight_in_12 = w22_q;
                sys_accept_w_2   = 1'b1;
                state_d          = LOAD2;
            end
            LOAD2: begin
                sys_weight_in_12 = w12_q;
                sys_accept_w_2   = 1'b1;
                sys_switch_in    = 1'b1;
                state_d          = STREAM;
            end
            STREAM: begin
                if (rows_left_d == 8'd0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Wait for the last tagged row to leave the result register before signalling done.
                if ((tag_q == '0) && !res_valid_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data11_d    = xfer ? in_x1 : 16'd0;
        x2_skew_d   = xfer ? in_x2 : 16'd0;
        data21_d    = x2_skew_q;
        tag_d       = {tag_q[TAG_W-2:0], xfer};
        // Column 1 result is ready one cycle before column 2, so hold it until both can issue together.
        y1_cap_d    = tag_q[OUT_LAT] ? sys_data_out_21 : y1_cap_q;
        res_valid_d = tag_q[OUT_LAT+1];
        res_y1_d    = tag_q[OUT_LAT+1] ? y1_cap_q : 16'd0;
        res_y2_d    = tag_q[OUT_LAT+1] ? sys_data_out_22 : 16'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_left_q <= 8'd0;
            w11_q       <= 16'd0;
            w12_q       <= 16'd0;
            w21_q       <= 16'd0;
            w22_q       <= 16'd0;
            data11_q    <= 16'd0;
            x2_skew_q   <= 16'd0;
            data21_q    <= 16'd0;
            tag_q       <= '0;
            y1_cap_q    <= 16'd0;
            res_valid_q <= 1'b0;
            res_y1_q    <= 16'd0;
            res_y2_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            rows_left_q <= rows_left_d;
            w11_q       <= w11_d;
            w12_q       <= w12_d;
            w21_q       <= w21_d;
            w22_q       <= w22_d;
            data11_q    <= data11_d;
            x2_skew_q   <= x2_skew_d;
            data21_q    <= data21_d;
            tag_q       <= tag_d;
            y1_cap_q    <= y1_cap_d;
            res_valid_q <= res_valid_d;
            res_y1_q    <= res_y1_d;
            res_y2_q    <= res_y2_d;
        end
    end

    assign sys_data_in_11 = data11_q;
    assign sys_data_in_21 = data21_q;
    assign res_valid      = res_valid_q;
    assign res_y1         = res_y1_q;
    assign res_y2         = res_y2_q;

endmodule
